// File: rtl/regs_op_ctrl.sv
// regs_op_ctrl: command-driven initiator for the Regs two-read/one-write
// register file. Accepts one command per valid/ready handshake, reads both
// operands through the Regs read ports, evaluates the operation and writes
// the result back through the Regs write port.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready         command handshake (ready only while idle)
//   cmd_op, cmd_rs/rt/rd, cmd_imm opcode, register fields, LI immediate
//   reg_Rs_addr_A, reg_Rt_addr_B  Regs read addresses (held until next accept)
//   rdata_A, rdata_B              Regs read data (combinational on addresses)
//   reg_Wt_addr, we, wdata        Regs write port
//   result, zero, overflow        last result and flags, held
//   done, err                     one-cycle completion / illegal-op pulses
module regs_op_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [4:0]  cmd_rd,
  input  logic [31:0] cmd_imm,
  output logic [4:0]  reg_Rs_addr_A,
  output logic [4:0]  reg_Rt_addr_B,
  output logic [4:0]  reg_Wt_addr,
  output logic        we,
  output logic [31:0] wdata,
  input  logic [31:0] rdata_A,
  input  logic [31:0] rdata_B,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_ready;
  logic        w_accept;

  logic [3:0]  r_op;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic [31:0] r_imm;
  logic [31:0] r_a;
  logic [31:0] r_b;

  logic [31:0] r_result;
  logic        r_zero;
  logic        r_ovf;
  logic [31:0] r_wdata;
  logic [4:0]  r_wt;
  logic        r_we;
  logic        r_done;
  logic        r_err;

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_res;
  logic        w_ovf;
  logic        w_err;
  logic        w_slt;

  // r_ready is only ever 1 in S_IDLE, so it alone qualifies the accept.
  assign w_accept = cmd_valid && r_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      // Registered ready: low out of reset, rises on the first edge after.
      r_ready <= (w_next == S_IDLE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- ALU
  assign w_sum  = r_a + r_b;
  assign w_diff = r_a - r_b;
  assign w_slt  = ($signed(r_a) < $signed(r_b));

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_err = 1'b0;
    case (r_op)
      4'd0: w_res = r_a & r_b;
      4'd1: w_res = r_a | r_b;
      4'd2: begin
        w_res = w_sum;
        w_ovf = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
      end
      4'd3: w_res = r_a ^ r_b;
      4'd4: w_res = ~(r_a | r_b);
      4'd5: w_res = r_b >> r_a[4:0];
      4'd6: begin
        w_res = w_diff;
        w_ovf = (r_a[31] != r_b[31]) && (w_diff[31] != r_a[31]);
      end
      4'd7: w_res = {31'b0, w_slt};
      4'd8: w_res = r_imm;
      default: w_err = 1'b1;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_wdata  <= '0;
      r_wt     <= '0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= cmd_op;
            r_rs  <= cmd_rs;
            r_rt  <= cmd_rt;
            r_rd  <= cmd_rd;
            r_imm <= cmd_imm;
          end
        end
        S_READ: begin
          r_a <= rdata_A;
          r_b <= rdata_B;
        end
        S_EXEC: begin
          r_result <= w_res;
          r_zero   <= (w_res == '0);
          r_ovf    <= w_ovf;
          r_wdata  <= w_res;
          r_wt     <= r_rd;
          r_we     <= !w_err && (r_rd != '0);
          r_done   <= 1'b1;
          r_err    <= w_err;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready     = r_ready;
  assign reg_Rs_addr_A = r_rs;
  assign reg_Rt_addr_B = r_rt;
  assign reg_Wt_addr   = r_wt;
  assign we            = r_we;
  assign wdata         = r_wdata;
  assign result        = r_result;
  assign zero          = r_zero;
  assign overflow      = r_ovf;
  assign done          = r_done;
  assign err           = r_err;

endmodule
